// File: rtl/conv_tile_ctrl.sv
// Job sequencer for the 3x3 PE array: latch operands, run the array, capture psums, hand off.
// Optional CONV_TILE_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module conv_tile_ctrl #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned RUN_CYCLES   = 7,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned TILE_CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [25*DATA_W-1:0]    in_ifmap_flat,
   input  logic [9*DATA_W-1:0]     in_filter_flat,
   output logic                    arr_rst,
   output logic                    arr_en,
   output logic [25*DATA_W-1:0]    arr_ifmap_flat,
   output logic [9*DATA_W-1:0]     arr_filter_flat,
   input  logic [9*DATA_W-1:0]     arr_sum_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [9*DATA_W-1:0]     out_sum_flat,
   output logic [TILE_CNT_W-1:0]   tile_cnt
`ifdef CONV_TILE_CTRL_PERF_EN
   ,
   output logic [31:0]             busy_cycles,
   output logic [31:0]             stall_cycles
`endif
);

   localparam int unsigned CntMax = (RUN_CYCLES > DRAIN_CYCLES) ? RUN_CYCLES : DRAIN_CYCLES;
   localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StOut} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [25*DATA_W-1:0]    ifmap_q, ifmap_d;
   logic [9*DATA_W-1:0]     filter_q, filter_d;
   logic [9*DATA_W-1:0]     sum_q, sum_d;
   logic [TILE_CNT_W-1:0]   tile_q, tile_d;
   logic                    accept, capture, handoff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ifmap_q  <= '0;
         filter_q <= '0;
         sum_q    <= '0;
         tile_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ifmap_q  <= ifmap_d;
         filter_q <= filter_d;
         sum_q    <= sum_d;
         tile_q   <= tile_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) state_d = StLoad;
            end
            StLoad: begin
               state_d = StRun;
               cnt_d   = CntW'(RUN_CYCLES - 1);
            end
            StRun: begin
               if (cnt_q == '0) begin
                  state_d = StDrain;
                  cnt_d   = CntW'(DRAIN_CYCLES - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StDrain: begin
               if (cnt_q == '0) state_d = StOut;
               else             cnt_d   = cnt_q - 1'b1;
            end
            StOut: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Flush overrides every handshake, including an offered job in IDLE.
   always_comb begin
      accept   = (state_q == StIdle) && in_valid && !flush;
      capture  = (state_q == StDrain) && (cnt_q == '0) && !flush;
      handoff  = (state_q == StOut) && out_ready && !flush;
      ifmap_d  = accept ? in_ifmap_flat : ifmap_q;
      filter_d = accept ? in_filter_flat : filter_q;
      sum_d    = sum_q;
      if (flush)        sum_d = '0;
      else if (capture) sum_d = arr_sum_flat;
      tile_d   = handoff ? tile_q + TILE_CNT_W'(1) : tile_q;
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      arr_en    = (state_q == StRun) || (state_q == StDrain);
      arr_rst   = !arr_en;
      out_valid = (state_q == StOut);
   end

   assign arr_ifmap_flat  = ifmap_q;
   assign arr_filter_flat = filter_q;
   assign out_sum_flat    = sum_q;
   assign tile_cnt        = tile_q;

`ifdef CONV_TILE_CTRL_PERF_EN
   logic [31:0] busy_q, busy_d, stall_q, stall_d;
   logic        busy_now, stall_now;

   always_comb begin
      busy_now  = (state_q == StLoad) || (state_q == StRun) || (state_q == StDrain);
      stall_now = (state_q == StOut) && !out_ready;
      busy_d    = busy_q;
      stall_d   = stall_q;
      if (busy_now && (busy_q != '1))   busy_d  = busy_q + 32'd1;
      if (stall_now && (stall_q != '1)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         busy_q  <= busy_d;
         stall_q <= stall_d;
      end
   end

   assign busy_cycles  = busy_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Bench for conv_tile_ctrl: job-age model compared every cycle plus directed literal checks.
module tb_conv_tile_ctrl;

   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [25*DW-1:0] in_ifmap_flat;
   logic [9*DW-1:0]  in_filter_flat;
   logic            arr_rst;
   logic            arr_en;
   logic [25*DW-1:0] arr_ifmap_flat;
   logic [9*DW-1:0]  arr_filter_flat;
   logic [9*DW-1:0]  arr_sum_flat;
   logic            out_valid;
   logic            out_ready;
   logic [9*DW-1:0]  out_sum_flat;
   logic [15:0]     tile_cnt;
`ifdef CONV_TILE_CTRL_PERF_EN
   logic [31:0]     busy_cycles;
   logic [31:0]     stall_cycles;
`endif

   conv_tile_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_ifmap_flat   (in_ifmap_flat),
      .in_filter_flat  (in_filter_flat),
      .arr_rst         (arr_rst),
      .arr_en          (arr_en),
      .arr_ifmap_flat  (arr_ifmap_flat),
      .arr_filter_flat (arr_filter_flat),
      .arr_sum_flat    (arr_sum_flat),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_sum_flat    (out_sum_flat),
      .tile_cnt        (tile_cnt)
`ifdef CONV_TILE_CTRL_PERF_EN
      ,
      .busy_cycles     (busy_cycles),
      .stall_cycles    (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int seed  = 0;

   task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Array stand-in: a fresh psum pattern every cycle so the capture instant is observable.
   always @(posedge clk) begin
      #1;
      seed++;
      for (int k = 0; k < 9; k++) arr_sum_flat[k*DW +: DW] = 8'(seed * 7 + k * 29);
   end

   // Model: a job is just its age in cycles since acceptance (1 = first cycle after accept).
   logic             m_busy;
   int               m_age;
   logic [15:0]      m_tiles;
   logic [25*DW-1:0] m_ifmap;
   logic [9*DW-1:0]  m_filter;
   logic [9*DW-1:0]  m_sum;
   logic [31:0]      m_bcyc;
   logic [31:0]      m_scyc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0; m_age = 0; m_tiles = '0;
         m_ifmap = '0; m_filter = '0; m_sum = '0; m_bcyc = '0; m_scyc = '0;
      end else begin
         if (m_busy && m_age <= 10) m_bcyc = m_bcyc + 32'd1;
         if (m_busy && m_age >= 11 && !out_ready) m_scyc = m_scyc + 32'd1;
         if (flush) begin
            m_busy = 1'b0;
         end else if (!m_busy) begin
            if (in_valid) begin
               m_busy = 1'b1; m_age = 1; m_ifmap = in_ifmap_flat; m_filter = in_filter_flat;
            end
         end else if (m_age >= 11) begin
            if (out_ready) begin
               m_busy = 1'b0; m_tiles = m_tiles + 16'd1;
            end
         end else begin
            if (m_age == 10) m_sum = arr_sum_flat;
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      logic e_en, e_ov;
      e_en = m_busy && (m_age >= 2) && (m_age <= 10);
      e_ov = m_busy && (m_age >= 11);
      check("m_in_ready", in_ready, !m_busy);
      check("m_arr_en", arr_en, e_en);
      check("m_arr_rst", arr_rst, !e_en);
      check("m_out_valid", out_valid, e_ov);
      check("m_tile_cnt", tile_cnt, m_tiles);
      check("m_arr_ifmap", arr_ifmap_flat, m_ifmap);
      check("m_arr_filter", arr_filter_flat, m_filter);
      if (e_ov) check("m_out_sum", out_sum_flat, m_sum);
`ifdef CONV_TILE_CTRL_PERF_EN
      check("m_busy_cycles", busy_cycles, m_bcyc);
      check("m_stall_cycles", stall_cycles, m_scyc);
`endif
   end

   function automatic logic [25*DW-1:0] mk_ifmap(input int base);
      logic [25*DW-1:0] r;
      for (int k = 0; k < 25; k++) r[k*DW +: DW] = 8'(base + k);
      return r;
   endfunction

   function automatic logic [9*DW-1:0] mk_filter(input int base);
      logic [9*DW-1:0] r;
      for (int k = 0; k < 9; k++) r[k*DW +: DW] = 8'(base);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after an edge with the DUT idle; returns one cycle after the accept edge.
   task automatic start_job(input logic [25*DW-1:0] ifm, input logic [9*DW-1:0] flt);
      in_ifmap_flat  = ifm;
      in_filter_flat = flt;
      in_valid       = 1'b1;
      step();
      in_valid       = 1'b0;
   endtask

   // Returns at the negedge of the first out_valid cycle; lat is that cycle's index after accept.
   task automatic run_to_out(output int lat, output int en_cnt, output logic [9*DW-1:0] snap);
      en_cnt = 0;
      snap   = '0;
      for (lat = 1; lat <= 30; lat++) begin
         @(negedge clk);
         if (arr_en) en_cnt++;
         if (lat == 10) snap = arr_sum_flat;
         if (out_valid) break;
         @(posedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int               lat, en_cnt, n_acc;
   int               acc_cyc [3];
   logic [9*DW-1:0]  snap, held;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_ifmap_flat = '0; in_filter_flat = '0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_arr_rst", arr_rst, 1'b1);
      check("reset_tile_cnt", tile_cnt, 16'd0);
      step();

      // Single job: ifmap k+1, filter all ones.
      start_job(mk_ifmap(1), mk_filter(1));
      run_to_out(lat, en_cnt, snap);
      check("single_latency", lat, 11);
      check("single_en_cycles", en_cnt, 9);
      check("single_capture", out_sum_flat, snap);
      check("single_ifmap_k0", arr_ifmap_flat[7:0], 8'd1);
      check("single_ifmap_k24", arr_ifmap_flat[199:192], 8'd25);
      step();
      @(negedge clk);
      check("single_tile_cnt", tile_cnt, 16'd1);
      step();

      // Back-pressure for 20 cycles, then release.
      out_ready = 1'b0;
      start_job(mk_ifmap(40), mk_filter(3));
      run_to_out(lat, en_cnt, snap);
      held = out_sum_flat;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_sum_stable", out_sum_flat, held);
         check("bp_in_ready", in_ready, 1'b0);
      end
      step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      check("bp_release_idle", in_ready, 1'b1);
      check("bp_release_ov", out_valid, 1'b0);
      check("bp_tile_cnt", tile_cnt, 16'd2);
      step();

      // Reset mid-RUN.
      start_job(mk_ifmap(90), mk_filter(5));
      repeat (3) step();
      rst = 1'b1;
      @(negedge clk);
      check("rst_arr_rst", arr_rst, 1'b1);
      check("rst_arr_en", arr_en, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_tile_cnt", tile_cnt, 16'd0);
      step();
      rst = 1'b0;
      step();

      // One job with exactly five stall cycles.
      out_ready = 1'b0;
      start_job(mk_ifmap(7), mk_filter(2));
      run_to_out(lat, en_cnt, snap);
      repeat (5) step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      check("stall_tile_cnt", tile_cnt, 16'd1);
`ifdef CONV_TILE_CTRL_PERF_EN
      check("perf_busy", busy_cycles, 32'd10);
      check("perf_stall", stall_cycles, 32'd5);
`endif
      step();

      // Back-to-back: in_valid held high for three jobs.
      do_reset();
      n_acc = 0;
      in_ifmap_flat = mk_ifmap(100); in_filter_flat = mk_filter(9);
      in_valid = 1'b1;
      for (int i = 0; i < 60 && n_acc < 3; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         step();
         if (n_acc == 3) in_valid = 1'b0;
         else in_ifmap_flat = mk_ifmap(100 + 10 * n_acc);
      end
      in_valid = 1'b0;
      check("b2b_accepts", n_acc, 3);
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 12);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 12);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tile_cnt == 16'd3) break;
      end
      check("b2b_tile_cnt", tile_cnt, 16'd3);
      step();

      // Flush together with in_valid while idle: no accept.
      in_ifmap_flat = mk_ifmap(200); in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_idle_no_accept", in_ready, 1'b1);
      step();

      // Flush in DRAIN.
      start_job(mk_ifmap(50), mk_filter(4));
      repeat (8) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_drain_idle", in_ready, 1'b1);
      check("flush_drain_ov", out_valid, 1'b0);
      check("flush_drain_tiles", tile_cnt, 16'd3);
      step();

      // Flush in OUT.
      out_ready = 1'b0;
      start_job(mk_ifmap(60), mk_filter(6));
      run_to_out(lat, en_cnt, snap);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_out_idle", in_ready, 1'b1);
      check("flush_out_ov", out_valid, 1'b0);
      check("flush_out_tiles", tile_cnt, 16'd3);
      step();

      // A fresh job after the flushes runs normally.
      start_job(mk_ifmap(70), mk_filter(8));
      run_to_out(lat, en_cnt, snap);
      check("post_flush_latency", lat, 11);
      check("post_flush_capture", out_sum_flat, snap);
      step();
      @(negedge clk);
      check("post_flush_tiles", tile_cnt, 16'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
